// File: rtl/wopt_pkg.sv
// rtl/wopt_pkg.sv - shared defaults, FSM states and saturation limits for the weight-update stage
package wopt_pkg;

  localparam int N_OUT_D    = 5;
  localparam int N_HID_D    = 8;
  localparam int DW_D       = 10;
  localparam int WW_D       = 16;
  localparam int LR_SHIFT_D = 3;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} wu_state_t;

  function automatic int sat_hi(input int ww);
    return (1 <<< (ww - 1)) - 1;
  endfunction

  function automatic int sat_lo(input int ww);
    return -(1 <<< (ww - 1));
  endfunction

  localparam int W_MAX = sat_hi(WW_D);
  localparam int W_MIN = sat_lo(WW_D);

endpackage

// File: rtl/weight_update0_if.sv
// rtl/weight_update0_if.sv - control, operand, preload and read-port bundle of the weight-update stage
interface weight_update0_if #(
  parameter int N_OUT = wopt_pkg::N_OUT_D,
  parameter int N_HID = wopt_pkg::N_HID_D,
  parameter int DW    = wopt_pkg::DW_D,
  parameter int WW    = wopt_pkg::WW_D
);

  logic                          start;
  logic [0:N_OUT-1]              sign0;
  logic [0:N_OUT-1][DW-1:0]      delta0;
  logic [0:N_HID-1][DW-1:0]      hid;
  logic                          busy;
  logic                          done;
  logic                          ld_en;
  logic [$clog2(N_OUT)-1:0]      ld_row;
  logic [$clog2(N_HID)-1:0]      ld_col;
  logic [WW-1:0]                 ld_data;
  logic [$clog2(N_OUT)-1:0]      rd_row;
  logic [$clog2(N_HID)-1:0]      rd_col;
  logic [WW-1:0]                 rd_data;

  modport master (
    output start, sign0, delta0, hid, ld_en, ld_row, ld_col, ld_data, rd_row, rd_col,
    input  busy, done, rd_data
  );

  modport slave (
    input  start, sign0, delta0, hid, ld_en, ld_row, ld_col, ld_data, rd_row, rd_col,
    output busy, done, rd_data
  );

endinterface

// File: rtl/weight_step.sv
// rtl/weight_step.sv - one weight update: w -/+ (delta*hid) >> (DW+LR_SHIFT), saturated to WW bits
module weight_step
  import wopt_pkg::*;
#(
  parameter int DW       = DW_D,
  parameter int WW       = WW_D,
  parameter int LR_SHIFT = LR_SHIFT_D
) (
  input  logic [DW-1:0]        delta,
  input  logic [DW-1:0]        hid,
  input  logic                 sign,
  input  logic signed [WW-1:0] w_cur,
  output logic signed [WW-1:0] w_new
);

  localparam logic signed [WW:0] HI = (WW+1)'(sat_hi(WW));
  localparam logic signed [WW:0] LO = (WW+1)'(sat_lo(WW));

  logic [2*DW-1:0]    prod;
  logic [2*DW-1:0]    shifted;
  logic signed [WW:0] step;
  logic signed [WW:0] sum;

  always_comb begin
    prod    = {{DW{1'b0}}, delta} * {{DW{1'b0}}, hid};
    shifted = prod >> (DW + LR_SHIFT);
    step    = (WW+1)'(shifted);
    // negative delta (sign=1) means the gradient step adds to the weight
    if (sign) sum = {w_cur[WW-1], w_cur} + step;
    else      sum = {w_cur[WW-1], w_cur} - step;
    if (sum > HI)      w_new = WW'(HI);
    else if (sum < LO) w_new = WW'(LO);
    else               w_new = WW'(sum);
  end

endmodule

// File: rtl/weight_update0.sv
// rtl/weight_update0.sv - output-layer weight update: latches deltas/activations, walks every weight once per pass
module weight_update0
  import wopt_pkg::*;
#(
  parameter int N_OUT    = N_OUT_D,
  parameter int N_HID    = N_HID_D,
  parameter int DW       = DW_D,
  parameter int WW       = WW_D,
  parameter int LR_SHIFT = LR_SHIFT_D
) (
  input  logic             clk,
  input  logic             rst,
  weight_update0_if.slave  bus
);

  localparam int RW = $clog2(N_OUT);
  localparam int CW = $clog2(N_HID);

  wu_state_t state, state_nx;

  logic [0:N_OUT-1]         sign_q;
  logic [0:N_OUT-1][DW-1:0] delta_q;
  logic [0:N_HID-1][DW-1:0] hid_q;

  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          last_idx;

  logic          iss_vld;
  logic [RW-1:0] iss_row;
  logic [CW-1:0] iss_col;

  logic          s1_vld;
  logic          s1_sign;
  logic [DW-1:0] s1_delta;
  logic [DW-1:0] s1_hid;
  logic [RW-1:0] s1_row;
  logic [CW-1:0] s1_col;

  logic signed [WW-1:0] w [N_OUT][N_HID];
  logic signed [WW-1:0] w_new;

  assign last_idx = (row == RW'(N_OUT - 1)) && (col == CW'(N_HID - 1));

  // DRAIN holds until the final write is on the stage-2 port, so done follows that write
  always_comb begin
    state_nx = state;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      IDLE:  if (bus.start) state_nx = RUN;
      RUN: begin
        bus.busy = 1'b1;
        if (last_idx) state_nx = DRAIN;
      end
      DRAIN: begin
        bus.busy = 1'b1;
        if (s1_vld && !iss_vld) state_nx = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  weight_step #(.DW(DW), .WW(WW), .LR_SHIFT(LR_SHIFT)) u_step (
    .delta (s1_delta),
    .hid   (s1_hid),
    .sign  (s1_sign),
    .w_cur (w[s1_row][s1_col]),
    .w_new (w_new)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sign_q   <= '0;
      delta_q  <= '0;
      hid_q    <= '0;
      row      <= '0;
      col      <= '0;
      iss_vld  <= 1'b0;
      iss_row  <= '0;
      iss_col  <= '0;
      s1_vld   <= 1'b0;
      s1_sign  <= 1'b0;
      s1_delta <= '0;
      s1_hid   <= '0;
      s1_row   <= '0;
      s1_col   <= '0;
      for (int r = 0; r < N_OUT; r++)
        for (int c = 0; c < N_HID; c++)
          w[r][c] <= '0;
    end else begin
      state <= state_nx;

      if (state == IDLE) begin
        if (bus.ld_en) w[bus.ld_row][bus.ld_col] <= bus.ld_data;
        if (bus.start) begin
          sign_q  <= bus.sign0;
          delta_q <= bus.delta0;
          hid_q   <= bus.hid;
          row     <= '0;
          col     <= '0;
        end
      end

      iss_vld <= (state == RUN);
      if (state == RUN) begin
        iss_row <= row;
        iss_col <= col;
        if (col == CW'(N_HID - 1)) begin
          col <= '0;
          row <= last_idx ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      s1_vld <= iss_vld;
      if (iss_vld) begin
        s1_sign  <= sign_q[iss_row];
        s1_delta <= delta_q[iss_row];
        s1_hid   <= hid_q[iss_col];
        s1_row   <= iss_row;
        s1_col   <= iss_col;
      end

      if (s1_vld) w[s1_row][s1_col] <= w_new;
    end
  end

  assign bus.rd_data = w[bus.rd_row][bus.rd_col];

endmodule

// File: tb/tb_weight_update0.sv
// tb/tb_weight_update0.sv - randomized self-checking bench for weight_update0 against an array model
module tb_weight_update0;
  import wopt_pkg::*;

  localparam int NO = N_OUT_D;
  localparam int NH = N_HID_D;
  localparam int PASS_LAT = NO * NH + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  weight_update0_if bus ();

  weight_update0 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests_run = 0;
  int fails     = 0;
  int exp_w [NO][NH];

  logic [0:NO-1]           sg;
  logic [0:NO-1][DW_D-1:0] dl;
  logic [0:NH-1][DW_D-1:0] hd;

  task automatic clr_model;
    for (int r = 0; r < NO; r++)
      for (int c = 0; c < NH; c++)
        exp_w[r][c] = 0;
  endtask

  task automatic model_pass;
    int step, nv;
    for (int r = 0; r < NO; r++)
      for (int c = 0; c < NH; c++) begin
        step = (int'(dl[r]) * int'(hd[c])) / (1 << (DW_D + LR_SHIFT_D));
        nv   = sg[r] ? exp_w[r][c] + step : exp_w[r][c] - step;
        if (nv > W_MAX) nv = W_MAX;
        if (nv < W_MIN) nv = W_MIN;
        exp_w[r][c] = nv;
      end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic read_w(input int r, input int c, output int v);
    bus.rd_row = 3'(r);
    bus.rd_col = 3'(c);
    #1;
    v = $signed(bus.rd_data);
  endtask

  task automatic load_w(input int r, input int c, input int v);
    bus.ld_en   = 1'b1;
    bus.ld_row  = 3'(r);
    bus.ld_col  = 3'(c);
    bus.ld_data = 16'(v);
    @(posedge clk);
    #1 bus.ld_en = 1'b0;
    exp_w[r][c] = v;
  endtask

  task automatic scramble_inputs;
    bus.sign0  = 5'($urandom);
    bus.delta0 = 50'({$urandom, $urandom});
    bus.hid    = 80'({$urandom, $urandom, $urandom});
  endtask

  task automatic rand_operands;
    sg = 5'($urandom);
    for (int r = 0; r < NO; r++) dl[r] = 10'($urandom);
    for (int c = 0; c < NH; c++) hd[c] = 10'($urandom);
  endtask

  // returns cycles from the start edge to the first cycle done is seen (-1 on timeout)
  task automatic run_pass(input bit with_ld, input int lr, input int lc, input int lv, output int lat);
    int cnt;
    bus.sign0  = sg;
    bus.delta0 = dl;
    bus.hid    = hd;
    bus.start  = 1'b1;
    if (with_ld) begin
      bus.ld_en   = 1'b1;
      bus.ld_row  = 3'(lr);
      bus.ld_col  = 3'(lc);
      bus.ld_data = 16'(lv);
      exp_w[lr][lc] = lv;
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.ld_en = 1'b0;
    scramble_inputs();
    model_pass();
    cnt = 0;
    while (bus.done !== 1'b1 && cnt < 200) begin
      @(posedge clk);
      #1 cnt++;
    end
    lat = (bus.done === 1'b1) ? cnt : -1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int v;
    do_reset();
    clr_model();
    tests_run++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b expected 0", bus.busy); end
    tests_run++;
    if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got %b expected 0", bus.done); end
    for (int r = 0; r < NO; r++)
      for (int c = 0; c < NH; c++) begin
        read_w(r, c, v);
        tests_run++;
        if (v !== 0) begin fails++; $display("FAIL reset_w W[%0d][%0d] got %0d expected 0", r, c, v); end
      end
  endtask

  task automatic test_single(input bit neg_delta);
    int v, lat;
    do_reset();
    clr_model();
    sg = '0; dl = '0; hd = '0;
    sg[0] = neg_delta;
    dl[0] = 10'd512;
    hd[0] = 10'd512;
    run_pass(1'b0, 0, 0, 0, lat);
    tests_run++;
    if (lat !== PASS_LAT) begin fails++; $display("FAIL single_latency got %0d expected %0d", lat, PASS_LAT); end
    read_w(0, 0, v);
    tests_run++;
    if (v !== (neg_delta ? 32 : -32)) begin
      fails++; $display("FAIL single_w00 got %0d expected %0d", v, neg_delta ? 32 : -32);
    end
    for (int r = 0; r < NO; r++)
      for (int c = 0; c < NH; c++) begin
        read_w(r, c, v);
        tests_run++;
        if (v !== exp_w[r][c]) begin fails++; $display("FAIL single_w W[%0d][%0d] got %0d expected %0d", r, c, v, exp_w[r][c]); end
      end
  endtask

  task automatic test_saturation;
    int v, lat;
    do_reset();
    clr_model();
    load_w(4, 7, 32767);
    load_w(4, 6, 32700);
    read_w(4, 7, v);
    tests_run++;
    if (v !== 32767) begin fails++; $display("FAIL sat_preload got %0d expected 32767", v); end
    sg = '0; dl = '0; hd = '0;
    sg[4] = 1'b1; dl[4] = 10'd1023; hd[7] = 10'd1023; hd[6] = 10'd1023;
    run_pass(1'b0, 0, 0, 0, lat);
    tests_run++;
    if (lat !== PASS_LAT) begin fails++; $display("FAIL sat_latency got %0d expected %0d", lat, PASS_LAT); end
    read_w(4, 7, v);
    tests_run++;
    if (v !== 32767) begin fails++; $display("FAIL sat_hi got %0d expected 32767", v); end
    read_w(4, 6, v);
    tests_run++;
    if (v !== exp_w[4][6]) begin fails++; $display("FAIL sat_hi_near got %0d expected %0d", v, exp_w[4][6]); end
    load_w(4, 7, -32768);
    sg[4] = 1'b0;
    run_pass(1'b0, 0, 0, 0, lat);
    read_w(4, 7, v);
    tests_run++;
    if (v !== -32768) begin fails++; $display("FAIL sat_lo got %0d expected -32768", v); end
  endtask

  task automatic test_random;
    int v, lat, pv;
    do_reset();
    clr_model();
    for (int it = 0; it < 4; it++) begin
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 3))
          0:       pv = W_MAX;
          1:       pv = W_MIN;
          default: pv = $signed(16'($urandom));
        endcase
        load_w($urandom_range(0, NO - 1), $urandom_range(0, NH - 1), pv);
      end
      rand_operands();
      pv = $signed(16'($urandom));
      run_pass(1'b1, $urandom_range(0, NO - 1), $urandom_range(0, NH - 1), pv, lat);
      tests_run++;
      if (lat !== PASS_LAT) begin fails++; $display("FAIL random_latency it%0d got %0d expected %0d", it, lat, PASS_LAT); end
      for (int r = 0; r < NO; r++)
        for (int c = 0; c < NH; c++) begin
          read_w(r, c, v);
          tests_run++;
          if (v !== exp_w[r][c]) begin fails++; $display("FAIL random_w it%0d W[%0d][%0d] got %0d expected %0d", it, r, c, v, exp_w[r][c]); end
        end
    end
  endtask

  task automatic test_ignore_busy;
    int v, cnt, lat;
    do_reset();
    clr_model();
    load_w(2, 3, 1000);
    rand_operands();
    bus.sign0  = sg;
    bus.delta0 = dl;
    bus.hid    = hd;
    bus.start  = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    model_pass();
    cnt = 0;
    while (bus.done !== 1'b1 && cnt < 200) begin
      bus.start   = (cnt >= 10 && cnt < 15);
      bus.ld_en   = (cnt >= 10 && cnt < 15);
      bus.ld_row  = 3'($urandom_range(0, NO - 1));
      bus.ld_col  = 3'($urandom_range(0, NH - 1));
      bus.ld_data = 16'($urandom);
      if (cnt == 12) scramble_inputs();
      @(posedge clk);
      #1 cnt++;
    end
    bus.start = 1'b0;
    bus.ld_en = 1'b0;
    lat = (bus.done === 1'b1) ? cnt : -1;
    @(posedge clk);
    #1;
    tests_run++;
    if (lat !== PASS_LAT) begin fails++; $display("FAIL ignore_latency got %0d expected %0d", lat, PASS_LAT); end
    tests_run++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL ignore_restart busy got %b expected 0", bus.busy); end
    for (int r = 0; r < NO; r++)
      for (int c = 0; c < NH; c++) begin
        read_w(r, c, v);
        tests_run++;
        if (v !== exp_w[r][c]) begin fails++; $display("FAIL ignore_w W[%0d][%0d] got %0d expected %0d", r, c, v, exp_w[r][c]); end
      end
  endtask

  task automatic test_rst_mid_pass;
    int v, lat;
    bit seen;
    do_reset();
    clr_model();
    load_w(1, 1, 12345);
    load_w(3, 5, -222);
    rand_operands();
    bus.sign0  = sg;
    bus.delta0 = dl;
    bus.hid    = hd;
    bus.start  = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b expected 0", bus.busy); end
    tests_run++;
    if (bus.done !== 1'b0) begin fails++; $display("FAIL rstmid_done got %b expected 0", bus.done); end
    rst = 1'b0;
    clr_model();
    for (int r = 0; r < NO; r++)
      for (int c = 0; c < NH; c++) begin
        read_w(r, c, v);
        tests_run++;
        if (v !== 0) begin fails++; $display("FAIL rstmid_w W[%0d][%0d] got %0d expected 0", r, c, v); end
      end
    seen = 1'b0;
    repeat (50) begin
      @(posedge clk);
      #1 if (bus.done === 1'b1) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin fails++; $display("FAIL rstmid_no_done got %b expected 0", seen); end
    rand_operands();
    run_pass(1'b0, 0, 0, 0, lat);
    tests_run++;
    if (lat !== PASS_LAT) begin fails++; $display("FAIL rstmid_fresh_latency got %0d expected %0d", lat, PASS_LAT); end
    for (int r = 0; r < NO; r++)
      for (int c = 0; c < NH; c++) begin
        read_w(r, c, v);
        tests_run++;
        if (v !== exp_w[r][c]) begin fails++; $display("FAIL rstmid_fresh_w W[%0d][%0d] got %0d expected %0d", r, c, v, exp_w[r][c]); end
      end
  endtask

  task automatic test_back_to_back;
    int v, lat1, lat2;
    do_reset();
    clr_model();
    sg = '0;
    for (int r = 0; r < NO; r++) dl[r] = 10'd100;
    for (int c = 0; c < NH; c++) hd[c] = 10'd256;
    run_pass(1'b0, 0, 0, 0, lat1);
    run_pass(1'b0, 0, 0, 0, lat2);
    tests_run++;
    if (lat1 !== PASS_LAT) begin fails++; $display("FAIL b2b_latency1 got %0d expected %0d", lat1, PASS_LAT); end
    tests_run++;
    if (lat2 !== PASS_LAT) begin fails++; $display("FAIL b2b_latency2 got %0d expected %0d", lat2, PASS_LAT); end
    for (int r = 0; r < NO; r++)
      for (int c = 0; c < NH; c++) begin
        read_w(r, c, v);
        tests_run++;
        if (v !== -6 || v !== exp_w[r][c]) begin
          fails++; $display("FAIL b2b_w W[%0d][%0d] got %0d expected %0d", r, c, v, exp_w[r][c]);
        end
      end
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.sign0   = '0;
    bus.delta0  = '0;
    bus.hid     = '0;
    bus.ld_en   = 1'b0;
    bus.ld_row  = '0;
    bus.ld_col  = '0;
    bus.ld_data = '0;
    bus.rd_row  = '0;
    bus.rd_col  = '0;
    sg = '0;
    dl = '0;
    hd = '0;
    test_reset();
    test_single(1'b0);
    test_single(1'b1);
    test_saturation();
    test_random();
    test_ignore_busy();
    test_rst_mid_pass();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
